// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the clock set/alarm controller.
//   state_e       - controller FSM encoding
//   BCD_*_MAX     - packed-BCD rollover limits for hours/minutes
//   ALARM_*_RST   - alarm time loaded at reset
//   bcd_inc()     - packed-BCD increment with wrap at a limit
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_ALM_HOUR = 3'd3,
    ST_ALM_MIN  = 3'd4
  } state_e;

  localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
  localparam logic [7:0] BCD_MIN_MAX    = 8'h59;
  localparam logic [7:0] ALARM_HOUR_RST = 8'h07;
  localparam logic [7:0] ALARM_MIN_RST  = 8'h00;

  // Keys are handled as a small lane array: index 0 = mode, 1 = inc.
  localparam int NUM_KEYS = 2;
  localparam int KEY_MODE = 0;
  localparam int KEY_INC  = 1;

  // Values at the limit wrap to 00; otherwise ones digit carries into tens at 9.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: turns a raw asynchronous push-button into one press pulse.
//   clk, rst  - system clock, async active-high reset
//   key_i     - raw key, active high, asynchronous to clk
//   press_o   - single-clk pulse once the key has been stable high for
//               DEBOUNCE_MS; no repeat while held
module key_debounce #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  localparam longint DB_L   = (longint'(CLK_HZ) * longint'(DEBOUNCE_MS)) / 64'sd1000;
  localparam int     DB_CYC = (DB_L < 1) ? 1 : int'(DB_L);
  localparam int     CW     = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DB_CYC - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          fired_q, fired_d;
  logic          press_q, press_d;
  logic          key_s;

  assign key_s   = sync_q[1];
  assign press_o = press_q;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    fired_d = fired_q;
    press_d = 1'b0;
    if (!key_s) begin
      // A low level both re-arms after reset and ends the current press.
      cnt_d   = '0;
      fired_d = 1'b0;
      armed_d = 1'b1;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CW'(1);
    end else if (armed_q && !fired_q) begin
      press_d = 1'b1;
      fired_d = 1'b1;
    end
  end

  // Synchronizer resets to "high" so a key already held at reset release is
  // never seen low, and so never arms until it is genuinely released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      fired_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      fired_q <= fired_d;
      press_q <= press_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting and alarm controller for a BCD tube clock.
//   clk, rst                  - system clock, async active-high reset
//   key_mode, key_inc         - raw buttons (debounced internally)
//   tick_1hz                  - one-clk pulse per second
//   hour, min, sec            - current time from the clock core (BCD)
//   en                        - run enable to the clock core
//   adjust_hour/minute        - increment requests, held across one tick
//   disp_hour/min/sec         - BCD values for the display
//   blank[5:0]                - per-digit dark mask (digits 5..0)
//   alarm_on, alarm_out       - alarm armed / ringing
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int RING_SEC    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       tick_1hz,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  output logic       en,
  output logic       adjust_hour,
  output logic       adjust_minute,
  output logic [7:0] disp_hour,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [5:0] blank,
  output logic       alarm_on,
  output logic       alarm_out
);

  localparam int PW = $clog2(CLK_HZ + 1);
  localparam logic [PW-1:0] PH_TOP  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PH_HALF = PW'(CLK_HZ / 2);
  localparam int RW = $clog2(RING_SEC + 1);
  localparam logic [RW-1:0] RING_TOP = RW'(RING_SEC - 1);

  logic [NUM_KEYS-1:0] key_raw, key_press;
  assign key_raw = {key_inc, key_mode};

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .CLK_HZ     (CLK_HZ),
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .key_i  (key_raw[k]),
      .press_o(key_press[k])
    );
  end

  state_e        state_q, state_d;
  logic          adj_h_q, adj_h_d, adj_m_q, adj_m_d;
  logic [7:0]    alm_h_q, alm_h_d, alm_m_q, alm_m_d;
  logic          alm_on_q, alm_on_d;
  logic          ring_q, ring_d;
  logic          match_q, match;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          mode_p, inc_p, mode_act, inc_act, adj_idle, half2;

  assign mode_p = key_press[KEY_MODE];
  assign inc_p  = key_press[KEY_INC];

  always_comb begin
    // While ringing, any press only silences; mode wins over a same-clk inc.
    mode_act = mode_p & ~ring_q;
    inc_act  = inc_p & ~mode_p & ~ring_q;
    adj_idle = ~adj_h_q & ~adj_m_q;

    state_d = state_q;
    if (mode_act) begin
      case (state_q)
        ST_RUN:      state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        ST_SET_MIN:  state_d = ST_ALM_HOUR;
        ST_ALM_HOUR: state_d = ST_ALM_MIN;
        default:     state_d = ST_RUN;
      endcase
    end

    // A pending adjust ends on the edge that samples tick_1hz, independent of
    // state, so the clock core sees exactly one increment.
    adj_h_d = adj_h_q ? ~tick_1hz : (inc_act && state_q == ST_SET_HOUR && adj_idle);
    adj_m_d = adj_m_q ? ~tick_1hz : (inc_act && state_q == ST_SET_MIN && adj_idle);

    alm_h_d  = alm_h_q;
    alm_m_d  = alm_m_q;
    alm_on_d = alm_on_q;
    if (inc_act && state_q == ST_ALM_HOUR) alm_h_d = bcd_inc(alm_h_q, BCD_HOUR_MAX);
    if (inc_act && state_q == ST_ALM_MIN)  alm_m_d = bcd_inc(alm_m_q, BCD_MIN_MAX);
    if (inc_act && state_q == ST_RUN)      alm_on_d = ~alm_on_q;

    match = (state_q == ST_RUN) && alm_on_q && (hour == alm_h_q) &&
            (min == alm_m_q) && (sec == 8'h00);

    // Ring starts on the rising edge of a match, so a silenced or expired
    // alarm does not restart during the same matching second.
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;
    if (ring_q) begin
      if (mode_p || inc_p || state_q != ST_RUN || !alm_on_q) begin
        ring_d     = 1'b0;
        ring_cnt_d = '0;
      end else if (tick_1hz) begin
        if (ring_cnt_q == RING_TOP) begin
          ring_d     = 1'b0;
          ring_cnt_d = '0;
        end else begin
          ring_cnt_d = ring_cnt_q + RW'(1);
        end
      end
    end else if (match && !match_q) begin
      ring_d     = 1'b1;
      ring_cnt_d = '0;
    end

    if (tick_1hz)              phase_d = '0;
    else if (phase_q == PH_TOP) phase_d = phase_q;
    else                        phase_d = phase_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      adj_h_q    <= 1'b0;
      adj_m_q    <= 1'b0;
      alm_h_q    <= ALARM_HOUR_RST;
      alm_m_q    <= ALARM_MIN_RST;
      alm_on_q   <= 1'b0;
      ring_q     <= 1'b0;
      match_q    <= 1'b0;
      ring_cnt_q <= '0;
      phase_q    <= '0;
    end else begin
      state_q    <= state_d;
      adj_h_q    <= adj_h_d;
      adj_m_q    <= adj_m_d;
      alm_h_q    <= alm_h_d;
      alm_m_q    <= alm_m_d;
      alm_on_q   <= alm_on_d;
      ring_q     <= ring_d;
      match_q    <= match;
      ring_cnt_q <= ring_cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign half2 = (phase_q >= PH_HALF);

  always_comb begin
    en        = 1'b1;
    blank     = 6'b000000;
    disp_hour = hour;
    disp_min  = min;
    disp_sec  = sec;
    case (state_q)
      ST_SET_HOUR: begin
        en = 1'b0;
        if (half2) blank = 6'b110000;
      end
      ST_SET_MIN: begin
        en = 1'b0;
        if (half2) blank = 6'b001100;
      end
      ST_ALM_HOUR: begin
        disp_hour = alm_h_q;
        disp_min  = alm_m_q;
        disp_sec  = 8'h00;
        if (half2) blank = 6'b110000;
      end
      ST_ALM_MIN: begin
        disp_hour = alm_h_q;
        disp_min  = alm_m_q;
        disp_sec  = 8'h00;
        if (half2) blank = 6'b001100;
      end
      default: ;
    endcase
  end

  assign adjust_hour   = adj_h_q;
  assign adjust_minute = adj_m_q;
  assign alarm_on      = alm_on_q;
  // Gated so ringing drops at once if RUN is left or the alarm is disarmed.
  assign alarm_out     = ring_q & alm_on_q & (state_q == ST_RUN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed bench with an expectation queue for clock_set_ctrl.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0, key_inc = 1'b0, tick_1hz = 1'b0;
  logic [7:0] hour = 8'h12, min = 8'h34, sec = 8'h56;
  logic       en, adjust_hour, adjust_minute, alarm_on, alarm_out;
  logic [7:0] disp_hour, disp_min, disp_sec;
  logic [5:0] blank;

  always #5 clk = ~clk;

  clock_set_ctrl #(.CLK_HZ(200), .DEBOUNCE_MS(20), .RING_SEC(60)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
    .tick_1hz(tick_1hz), .hour(hour), .min(min), .sec(sec),
    .en(en), .adjust_hour(adjust_hour), .adjust_minute(adjust_minute),
    .disp_hour(disp_hour), .disp_min(disp_min), .disp_sec(disp_sec),
    .blank(blank), .alarm_on(alarm_on), .alarm_out(alarm_out)
  );

  // Count tick edges on which each adjust request is seen high.
  int adjh_edges = 0, adjm_edges = 0;
  always @(posedge clk) begin
    if (tick_1hz && adjust_hour)   adjh_edges <= adjh_edges + 1;
    if (tick_1hz && adjust_minute) adjm_edges <= adjm_edges + 1;
  end

  typedef enum int {S_EN, S_ADJH, S_ADJM, S_DH, S_DM, S_DS, S_BLANK,
                    S_AON, S_AOUT, S_HEDG, S_MEDG} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;

  task automatic want(input string tag, input sig_e s, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.sig = s; x.exp = e;
    sb.push_back(x);
  endtask

  function automatic logic [31:0] obs(input sig_e s);
    case (s)
      S_EN:    return {31'h0, en};
      S_ADJH:  return {31'h0, adjust_hour};
      S_ADJM:  return {31'h0, adjust_minute};
      S_DH:    return {24'h0, disp_hour};
      S_DM:    return {24'h0, disp_min};
      S_DS:    return {24'h0, disp_sec};
      S_BLANK: return {26'h0, blank};
      S_AON:   return {31'h0, alarm_on};
      S_AOUT:  return {31'h0, alarm_out};
      S_HEDG:  return 32'(adjh_edges);
      default: return 32'(adjm_edges);
    endcase
  endfunction

  task automatic check();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      assert (obs(x.sig) === x.exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", x.tag, obs(x.sig), x.exp);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    @(negedge clk) tick_1hz = 1'b1;
    @(negedge clk) tick_1hz = 1'b0;
    cyc(2);
  endtask

  task automatic press(input logic m, input logic i);
    @(negedge clk);
    key_mode = m; key_inc = i;
    cyc(12);
    key_mode = 1'b0; key_inc = 1'b0;
    cyc(12);
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'((v / 10) * 16 + (v % 10));
  endfunction

  int ah, am;

  initial begin
    // Reset with mode key already held.
    key_mode = 1'b1;
    cyc(5);
    want("rst_en", S_EN, 1); want("rst_adjh", S_ADJH, 0); want("rst_adjm", S_ADJM, 0);
    want("rst_blank", S_BLANK, 0); want("rst_aon", S_AON, 0); want("rst_aout", S_AOUT, 0);
    want("rst_disp_hour", S_DH, 32'h12);
    check();
    rst = 1'b0;
    cyc(30);
    want("held_key_en", S_EN, 1); want("held_key_dsec", S_DS, 32'h56);
    check();
    key_mode = 1'b0;
    cyc(30);
    want("released_key_en", S_EN, 1); want("released_key_dsec", S_DS, 32'h56);
    check();

    // SET_HOUR: one adjust across one tick; second inc ignored.
    press(1, 0);
    want("sethour_en", S_EN, 0); want("sethour_dh", S_DH, 32'h12);
    check();
    press(0, 1);
    want("adjh_set", S_ADJH, 1);
    check();
    press(0, 1);
    want("adjh_still", S_ADJH, 1); want("adjh_edges0", S_HEDG, 0);
    check();
    tick();
    want("adjh_clr", S_ADJH, 0); want("adjh_edges1", S_HEDG, 1);
    check();
    tick();
    want("adjh_stay_clr", S_ADJH, 0); want("adjh_edges_once", S_HEDG, 1);
    check();
    cyc(20);
    want("blank_h_first_half", S_BLANK, 0);
    check();
    cyc(130);
    want("blank_h_second_half", S_BLANK, 32'b110000);
    check();

    // SET_MIN with adjust pending across the move to ALM_HOUR.
    press(1, 0);
    want("setmin_en", S_EN, 0); want("setmin_blank", S_BLANK, 32'b001100);
    check();
    press(0, 1);
    want("adjm_set", S_ADJM, 1); want("adjm_no_adjh", S_ADJH, 0);
    check();
    press(1, 0);
    want("almh_en", S_EN, 1); want("adjm_pending", S_ADJM, 1);
    want("alm_default_h", S_DH, 32'h07); want("alm_default_m", S_DM, 32'h00);
    want("alm_dsec", S_DS, 32'h00); want("almh_blank", S_BLANK, 32'b110000);
    check();
    tick();
    want("adjm_clr", S_ADJM, 0); want("adjm_edges1", S_MEDG, 1);
    want("almh_blank_first_half", S_BLANK, 0);
    check();

    // ALM_HOUR: 24 increments wrap back to 07.
    ah = 7;
    for (int i = 0; i < 24; i++) begin
      press(0, 1);
      ah = (ah + 1) % 24;
      want($sformatf("alm_hour_%0d", i), S_DH, to_bcd(ah));
      check();
    end

    // ALM_MIN: 60 increments wrap 59 -> 00.
    press(1, 0);
    am = 0;
    for (int i = 0; i < 60; i++) begin
      press(0, 1);
      am = (am + 1) % 60;
      want($sformatf("alm_min_%0d", i), S_DM, to_bcd(am));
      check();
    end
    want("alm_min_keeps_hour", S_DH, 32'h07);
    check();

    press(1, 0);
    want("run_en", S_EN, 1); want("run_blank", S_BLANK, 0); want("run_dsec", S_DS, 32'h56);
    check();

    // Alarm ring: full duration, then silenced by a key.
    press(0, 1);
    want("arm_toggle", S_AON, 1); want("arm_no_ring", S_AOUT, 0);
    check();
    hour = 8'h07; min = 8'h00; sec = 8'h00;
    cyc(3);
    want("ring_start", S_AOUT, 1);
    check();
    for (int i = 0; i < 59; i++) tick();
    want("ring_tick59", S_AOUT, 1);
    check();
    tick();
    want("ring_tick60_off", S_AOUT, 0); want("ring_expire_aon", S_AON, 1);
    check();
    sec = 8'h01; cyc(3); sec = 8'h00; cyc(3);
    want("ring_again", S_AOUT, 1);
    check();
    for (int i = 0; i < 5; i++) tick();
    want("ring_tick5", S_AOUT, 1);
    check();
    press(0, 1);
    want("ring_key_off", S_AOUT, 0); want("ring_key_aon", S_AON, 1); want("ring_key_en", S_EN, 1);
    check();
    sec = 8'h01;
    cyc(3);

    // Mode and inc together: mode only.
    press(1, 1);
    want("both_en", S_EN, 0); want("both_aon", S_AON, 1); want("both_adjh", S_ADJH, 0);
    check();
    tick();
    want("both_edges", S_HEDG, 1);
    check();

    // Async reset while an adjust is pending in SET_MIN.
    press(1, 0);
    press(0, 1);
    want("pre_rst_adjm", S_ADJM, 1); want("pre_rst_en", S_EN, 0);
    check();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    want("arst_en", S_EN, 1); want("arst_adjm", S_ADJM, 0); want("arst_adjh", S_ADJH, 0);
    want("arst_blank", S_BLANK, 0); want("arst_aon", S_AON, 0); want("arst_aout", S_AOUT, 0);
    check();
    cyc(4);
    rst = 1'b0;
    cyc(4);
    press(1, 0); press(1, 0); press(1, 0);
    want("post_rst_alm_h", S_DH, 32'h07); want("post_rst_alm_m", S_DM, 32'h00);
    check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
